// File: rtl/demux_1to2_router.sv
// Packet router: steers whole valid/ready packets to y0 or y1 (header-directed or round-robin) through a one-entry output register.
// Latency 1 cycle; in_ready follows the ready of the held beat's output, so streaming has no bubbles and a stalled output stalls the input.
module demux_1to2_router #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             in_dest,
    input  logic             mode,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0_data,
    output logic             y0_valid,
    output logic             y0_last,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y1_data,
    output logic             y1_valid,
    output logic             y1_last,
    input  logic             y1_ready,
    output logic             sel,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    typedef enum logic {IDLE = 1'b0, ROUTE = 1'b1} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic             last;
        logic             dest;
        logic             vld;
    } hold_t;

    state_t           state_q, state_d;
    hold_t            hold_q, hold_d;
    logic             sel_q, sel_d;
    logic             rr_next_q, rr_next_d;
    logic             rr_pkt_q, rr_pkt_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic hold_rdy;
    logic deliver;
    logic accept;
    logic route;
    logic pkt_rr;

    assign hold_rdy = hold_q.dest ? y1_ready : y0_ready;
    assign deliver  = hold_q.vld & hold_rdy;
    assign in_ready = ~hold_q.vld | hold_rdy;
    assign accept   = in_valid & in_ready;

    // Route and round-robin origin are taken from the inputs only on a packet's first beat.
    assign route  = (state_q == IDLE) ? (mode ? rr_next_q : in_dest) : sel_q;
    assign pkt_rr = (state_q == IDLE) ? mode : rr_pkt_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        sel_d     = sel_q;
        rr_next_d = rr_next_q;
        rr_pkt_d  = rr_pkt_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;

        if (deliver) begin
            hold_d.vld = 1'b0;
            if (hold_q.last) begin
                if (hold_q.dest) cnt1_d = cnt1_q + CNT_W'(1);
                else             cnt0_d = cnt0_q + CNT_W'(1);
            end
        end

        if (accept) begin
            hold_d.dat  = in_data;
            hold_d.last = in_last;
            hold_d.dest = route;
            hold_d.vld  = 1'b1;
            if (state_q == IDLE) begin
                sel_d    = route;
                rr_pkt_d = mode;
            end
            if (in_last) begin
                state_d = IDLE;
                if (pkt_rr) rr_next_d = ~rr_next_q;
            end else begin
                state_d = ROUTE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            sel_q     <= 1'b0;
            rr_next_q <= 1'b0;
            rr_pkt_q  <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            sel_q     <= sel_d;
            rr_next_q <= rr_next_d;
            rr_pkt_q  <= rr_pkt_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    assign y0_valid = hold_q.vld & ~hold_q.dest;
    assign y1_valid = hold_q.vld &  hold_q.dest;
    assign y0_data  = y0_valid ? hold_q.dat : '0;
    assign y1_data  = y1_valid ? hold_q.dat : '0;
    assign y0_last  = y0_valid & hold_q.last;
    assign y1_last  = y1_valid & hold_q.last;
    assign sel      = sel_q;
    assign busy     = (state_q == ROUTE) | hold_q.vld;
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_demux_1to2_router.sv
// Directed bench for demux_1to2_router: hand-computed expectations for routing, backpressure, reset and counter wrap.
module tb_demux_1to2_router;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid, in_last, in_dest, mode, in_ready;
    logic [7:0] y0_data, y1_data;
    logic       y0_valid, y0_last, y0_ready;
    logic       y1_valid, y1_last, y1_ready;
    logic       sel, busy;
    logic [7:0] pkt_cnt0, pkt_cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    demux_1to2_router #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_dest(in_dest), .mode(mode), .in_ready(in_ready),
        .y0_data(y0_data), .y0_valid(y0_valid), .y0_last(y0_last), .y0_ready(y0_ready),
        .y1_data(y1_data), .y1_valid(y1_valid), .y1_last(y1_last), .y1_ready(y1_ready),
        .sel(sel), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Drive one beat, wait (bounded) for acceptance, then check it on the expected output.
    task automatic send(input logic [7:0] d, input logic l, input logic dst,
                        input logic md, input logic port);
        int n;
        in_data = d; in_last = l; in_dest = dst; mode = md; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("accept_timeout", in_ready, 1);
        step();
        if (port) begin
            chk("y1_valid", y1_valid, 1);
            chk("y1_data", y1_data, d);
            chk("y1_last", y1_last, l);
            chk("y0_valid", y0_valid, 0);
        end else begin
            chk("y0_valid", y0_valid, 1);
            chk("y0_data", y0_data, d);
            chk("y0_last", y0_last, l);
            chk("y1_valid", y1_valid, 0);
        end
        chk("sel", sel, port);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        in_dest = 1'b0; mode = 1'b0; y0_ready = 1'b1; y1_ready = 1'b1;

        // Reset state
        do_reset();
        chk("rst_y0_valid", y0_valid, 0);
        chk("rst_y1_valid", y1_valid, 0);
        chk("rst_y0_data", y0_data, 0);
        chk("rst_y1_last", y1_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", sel, 0);
        chk("rst_cnt0", pkt_cnt0, 0);
        chk("rst_cnt1", pkt_cnt1, 0);
        chk("rst_in_ready", in_ready, 1);

        // Mode 0: two 3-beat packets, dest 1 then 0
        send(8'h11, 0, 1, 0, 1);
        chk("t1_busy", busy, 1);
        send(8'h12, 0, 0, 0, 1);
        send(8'h13, 1, 0, 0, 1);
        send(8'h21, 0, 0, 0, 0);
        send(8'h22, 0, 1, 0, 0);
        send(8'h23, 1, 1, 0, 0);
        idle();
        chk("t1_cnt0", pkt_cnt0, 1);
        chk("t1_cnt1", pkt_cnt1, 1);
        chk("t1_busy_end", busy, 0);

        // Mode 0: in_dest toggling inside a dest=0 packet
        do_reset();
        send(8'h31, 0, 0, 0, 0);
        send(8'h32, 0, 1, 0, 0);
        send(8'h33, 0, 0, 1, 0);
        send(8'h34, 1, 1, 1, 0);
        idle();
        chk("t2_cnt0", pkt_cnt0, 1);
        chk("t2_cnt1", pkt_cnt1, 0);

        // Mode 1: round-robin single-beat packets
        do_reset();
        send(8'hA0, 1, 1, 1, 0);
        send(8'hA1, 1, 0, 1, 1);
        send(8'hA2, 1, 1, 1, 0);
        send(8'hA3, 1, 0, 1, 1);
        idle();
        chk("t3_cnt0", pkt_cnt0, 2);
        chk("t3_cnt1", pkt_cnt1, 2);
        send(8'hA4, 1, 1, 1, 0);
        // A mode-0 packet leaves the pointer where it was
        send(8'hA5, 1, 0, 0, 0);
        send(8'hA6, 1, 0, 1, 1);
        idle();

        // Backpressure on y1 with a 2-beat packet
        do_reset();
        y1_ready = 1'b0;
        send(8'hB1, 0, 1, 0, 1);
        in_data = 8'hB2; in_last = 1'b1; in_dest = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold", y1_data, 8'hB1);
            chk("bp_valid", y1_valid, 1);
            step();
        end
        y1_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        chk("bp_b2_data", y1_data, 8'hB2);
        chk("bp_b2_last", y1_last, 1);
        chk("bp_b2_valid", y1_valid, 1);
        chk("bp_cnt1_mid", pkt_cnt1, 0);
        idle();
        chk("bp_drained", y1_valid, 0);
        chk("bp_cnt1", pkt_cnt1, 1);
        chk("bp_cnt0", pkt_cnt0, 0);

        // Reset mid-packet
        do_reset();
        send(8'hC1, 0, 1, 0, 1);
        send(8'hC2, 0, 1, 0, 1);
        do_reset();
        chk("mr_y0_valid", y0_valid, 0);
        chk("mr_y1_valid", y1_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_cnt1", pkt_cnt1, 0);
        send(8'hD0, 1, 0, 0, 0);
        send(8'hD1, 1, 1, 0, 1);
        idle();
        chk("mr_cnt0", pkt_cnt0, 1);
        chk("mr_cnt1_end", pkt_cnt1, 1);

        // Counter wrap: 256 single-beat packets to y0
        do_reset();
        for (int i = 0; i < 256; i++) send(8'(i), 1, 0, 0, 0);
        chk("wrap_cnt0_255", pkt_cnt0, 255);
        idle();
        chk("wrap_cnt0", pkt_cnt0, 0);
        chk("wrap_cnt1", pkt_cnt1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
